// File: rtl/pc_unit.sv
// pc_unit -- program counter, instruction register and processor flag unit.
//
// Holds the program counter, the current instruction word and the five
// processor flags. It evaluates the 4-bit condition field of the held
// instruction, and it resolves increment, jump (JAL/Jcond) and relative
// branch (Bcond) updates of the PC.
//
// Optional feature (compile-time macro): FLAG_BYPASS_EN
//   When defined, a conditional jump/branch issued in the same cycle as a
//   flag write evaluates its condition on the incoming alu* flags.
//   When undefined, conditions always use the registered flags.
//
// Ports
//   clk          in   1  rising-edge clock
//   reset        in   1  synchronous, active-high reset
//   pcEn         in   2  00 hold, 01 increment, 10 jump (JAL/Jcond), 11 branch (Bcond)
//   pcRegEn      in   1  load memData into the instruction register
//   memData      in  16  instruction word from memory
//   jumpTarget   in  16  absolute target for JAL/Jcond
//   flagWrEn     in   1  latch the ALU flags
//   aluC..aluN   in   1  flags from the ALU
//   pc           out 16  registered program counter
//   instruction  out 16  registered instruction word
//   C,L,F,Z,N    out  1  registered processor flags
//   linkAddr     out 16  combinational pc+1 (JAL return address)
//   branchTaken  out  1  one-cycle pulse after a taken jump/branch
module pc_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  pcEn,
  input  logic        pcRegEn,
  input  logic [15:0] memData,
  input  logic [15:0] jumpTarget,
  input  logic        flagWrEn,
  input  logic        aluC,
  input  logic        aluL,
  input  logic        aluF,
  input  logic        aluZ,
  input  logic        aluN,
  output logic [15:0] pc,
  output logic [15:0] instruction,
  output logic        C,
  output logic        L,
  output logic        F,
  output logic        Z,
  output logic        N,
  output logic [15:0] linkAddr,
  output logic        branchTaken
);

  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_JUMP = 2'b10;
  localparam logic [1:0] PC_BR   = 2'b11;

  localparam logic [3:0] JAL_OPX = 4'b1000;

  logic [15:0]        r_pc;
  logic [15:0]        r_instr;
  logic [4:0]         r_flags;      // {C,L,F,Z,N}
  logic               r_bt;

  logic [4:0]         w_alu_flags;
  logic [4:0]         w_eval_flags;
  logic [3:0]         w_cond;
  logic               w_cond_true;
  logic               w_is_jal;
  logic signed [15:0] w_disp;
  logic [15:0]        w_pc_inc;
  logic [15:0]        w_pc_br;
  logic [15:0]        w_pc_next;
  logic               w_taken;

  assign w_alu_flags = {aluC, aluL, aluF, aluZ, aluN};

`ifdef FLAG_BYPASS_EN
  // Forward the flags being written this cycle so a compare followed
  // immediately by a branch sees the fresh result.
  assign w_eval_flags = flagWrEn ? w_alu_flags : r_flags;
`else
  assign w_eval_flags = r_flags;
`endif

  assign w_cond   = r_instr[11:8];
  assign w_is_jal = (r_instr[7:4] == JAL_OPX);

  // 8-bit signed displacement, sign-extended; the 16-bit add wraps naturally.
  assign w_disp   = {{8{r_instr[7]}}, r_instr[7:0]};
  assign w_pc_inc = r_pc + 16'd1;
  assign w_pc_br  = r_pc + $unsigned(w_disp);

  always_comb begin
    logic fc, fl, ff, fz, fn;
    {fc, fl, ff, fz, fn} = w_eval_flags;
    w_cond_true = 1'b0;
    case (w_cond)
      4'b0000: w_cond_true = fz;
      4'b0001: w_cond_true = !fz;
      4'b0010: w_cond_true = fc;
      4'b0011: w_cond_true = !fc;
      4'b0100: w_cond_true = fl;
      4'b0101: w_cond_true = !fl;
      4'b0110: w_cond_true = fn;
      4'b0111: w_cond_true = !fn;
      4'b1000: w_cond_true = ff;
      4'b1001: w_cond_true = !ff;
      4'b1010: w_cond_true = !fl && !fz;
      4'b1011: w_cond_true = fl || fz;
      4'b1100: w_cond_true = !fn && !fz;
      4'b1101: w_cond_true = fn || fz;
      4'b1110: w_cond_true = 1'b1;
      default: w_cond_true = 1'b0;
    endcase
  end

  always_comb begin
    w_pc_next = r_pc;
    w_taken   = 1'b0;
    case (pcEn)
      PC_HOLD: w_pc_next = r_pc;
      PC_INC:  w_pc_next = w_pc_inc;
      PC_JUMP: begin
        // JAL ignores the condition field; Jcond falls through to pc+1.
        if (w_is_jal || w_cond_true) begin
          w_pc_next = jumpTarget;
          w_taken   = 1'b1;
        end else begin
          w_pc_next = w_pc_inc;
        end
      end
      PC_BR: begin
        if (w_cond_true) begin
          w_pc_next = w_pc_br;
          w_taken   = 1'b1;
        end else begin
          w_pc_next = w_pc_inc;
        end
      end
      default: w_pc_next = r_pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= 16'h0000;
      r_instr <= 16'h0000;
      r_flags <= 5'b00000;
      r_bt    <= 1'b0;
    end else begin
      r_pc <= w_pc_next;
      r_bt <= w_taken;
      if (pcRegEn) begin
        r_instr <= memData;
      end
      if (flagWrEn) begin
        r_flags <= w_alu_flags;
      end
    end
  end

  assign pc                = r_pc;
  assign instruction       = r_instr;
  assign {C, L, F, Z, N}   = r_flags;
  assign branchTaken       = r_bt;
  assign linkAddr          = w_pc_inc;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit -- self-checking bench for pc_unit.
// A table of directed vectors plus a generated sweep over every condition
// code. Expected post-edge state is queued when a vector is driven and is
// popped and compared after the clock edge.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  pcEn = 2'b00;
  logic        pcRegEn = 1'b0;
  logic [15:0] memData = 16'h0000;
  logic [15:0] jumpTarget = 16'h0000;
  logic        flagWrEn = 1'b0;
  logic        aluC = 1'b0, aluL = 1'b0, aluF = 1'b0, aluZ = 1'b0, aluN = 1'b0;
  logic [15:0] pc, instruction, linkAddr;
  logic        C, L, F, Z, N, branchTaken;

  pc_unit dut (
    .clk(clk), .reset(reset), .pcEn(pcEn), .pcRegEn(pcRegEn),
    .memData(memData), .jumpTarget(jumpTarget), .flagWrEn(flagWrEn),
    .aluC(aluC), .aluL(aluL), .aluF(aluF), .aluZ(aluZ), .aluN(aluN),
    .pc(pc), .instruction(instruction),
    .C(C), .L(L), .F(F), .Z(Z), .N(N),
    .linkAddr(linkAddr), .branchTaken(branchTaken)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  en;
    logic        ir_en;
    logic [15:0] mem;
    logic [15:0] jt;
    logic        fwe;
    logic [4:0]  alu;       // {C,L,F,Z,N}
    logic        chk_link;
    logic [15:0] exp_link;  // linkAddr before the edge
    logic [15:0] exp_pc;
    logic [15:0] exp_ir;
    logic [4:0]  exp_fl;
    logic        exp_bt;
  } vec_t;

  typedef struct {
    int          tag;
    logic [15:0] pc;
    logic [15:0] ir;
    logic [4:0]  fl;
    logic        bt;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(input logic rst, input logic [1:0] en, input logic ir_en,
                              input logic [15:0] mem, input logic [15:0] jt,
                              input logic fwe, input logic [4:0] alu,
                              input logic chk, input logic [15:0] link,
                              input logic [15:0] epc, input logic [15:0] eir,
                              input logic [4:0] efl, input logic ebt);
    vec_t v;
    v.rst = rst; v.en = en; v.ir_en = ir_en; v.mem = mem; v.jt = jt;
    v.fwe = fwe; v.alu = alu; v.chk_link = chk; v.exp_link = link;
    v.exp_pc = epc; v.exp_ir = eir; v.exp_fl = efl; v.exp_bt = ebt;
    return v;
  endfunction

  // Condition table, written straight from the condition-code definitions.
  function automatic logic cond_ok(input logic [3:0] c, input logic [4:0] f);
    logic fc, fl, ff, fz, fn;
    {fc, fl, ff, fz, fn} = f;
    case (c)
      4'h0: return fz;          4'h1: return !fz;
      4'h2: return fc;          4'h3: return !fc;
      4'h4: return fl;          4'h5: return !fl;
      4'h6: return fn;          4'h7: return !fn;
      4'h8: return ff;          4'h9: return !ff;
      4'hA: return !fl && !fz;  4'hB: return fl || fz;
      4'hC: return !fn && !fz;  4'hD: return fn || fz;
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check16(input string name, input int tag, input logic [15:0] act,
                         input logic [15:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s[%0d] got %h expected %h", name, tag, act, req);
    end
  endtask

  task automatic apply(input vec_t v, input int tag);
    exp_t e;
    @(negedge clk);
    reset = v.rst; pcEn = v.en; pcRegEn = v.ir_en; memData = v.mem;
    jumpTarget = v.jt; flagWrEn = v.fwe;
    {aluC, aluL, aluF, aluZ, aluN} = v.alu;
    #1;
    if (v.chk_link) check16("linkAddr", tag, linkAddr, v.exp_link);
    e.tag = tag; e.pc = v.exp_pc; e.ir = v.exp_ir; e.fl = v.exp_fl; e.bt = v.exp_bt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard[%0d] got empty queue expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      check16("pc", e.tag, pc, e.pc);
      check16("instruction", e.tag, instruction, e.ir);
      check16("flags", e.tag, {11'd0, C, L, F, Z, N}, {11'd0, e.fl});
      check16("branchTaken", e.tag, {15'd0, branchTaken}, {15'd0, e.bt});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] p15;
    logic        bt15;
    logic [15:0] epc;
    logic [4:0]  pats [4];
    logic        tk;
`ifdef FLAG_BYPASS_EN
    p15 = 16'h03FF; bt15 = 1'b1;
`else
    p15 = 16'h0402; bt15 = 1'b0;
`endif
    //              rst en    ir mem      jt       fwe alu     chk link     pc       ir       fl      bt
    vecs.push_back(mk(1, 2'b01, 1, 16'hFFFF, 16'h0000, 1, 5'h1F, 0, 16'h0000, 16'h0000, 16'h0000, 5'h00, 0));
    vecs.push_back(mk(0, 2'b01, 0, 16'h0000, 16'h0000, 0, 5'h00, 1, 16'h0001, 16'h0001, 16'h0000, 5'h00, 0));
    vecs.push_back(mk(0, 2'b01, 0, 16'h0000, 16'h0000, 0, 5'h00, 1, 16'h0002, 16'h0002, 16'h0000, 5'h00, 0));
    vecs.push_back(mk(0, 2'b01, 0, 16'h0000, 16'h0000, 0, 5'h00, 1, 16'h0003, 16'h0003, 16'h0000, 5'h00, 0));
    vecs.push_back(mk(0, 2'b00, 1, 16'h4E80, 16'h0000, 0, 5'h00, 1, 16'h0004, 16'h0003, 16'h4E80, 5'h00, 0));
    vecs.push_back(mk(0, 2'b10, 1, 16'hC0FE, 16'h0010, 1, 5'h02, 1, 16'h0004, 16'h0010, 16'hC0FE, 5'h02, 1));
    vecs.push_back(mk(0, 2'b11, 0, 16'h0000, 16'h0000, 0, 5'h00, 1, 16'h0011, 16'h000E, 16'hC0FE, 5'h02, 1));
    vecs.push_back(mk(0, 2'b01, 0, 16'h0000, 16'h0000, 0, 5'h00, 1, 16'h000F, 16'h000F, 16'hC0FE, 5'h02, 0));
    vecs.push_back(mk(0, 2'b01, 0, 16'h0000, 16'h0000, 1, 5'h00, 1, 16'h0010, 16'h0010, 16'hC0FE, 5'h00, 0));
    vecs.push_back(mk(0, 2'b11, 0, 16'h0000, 16'h0000, 0, 5'h00, 1, 16'h0011, 16'h0011, 16'hC0FE, 5'h00, 0));
    vecs.push_back(mk(0, 2'b00, 1, 16'h4CC0, 16'h0000, 0, 5'h00, 1, 16'h0012, 16'h0011, 16'h4CC0, 5'h00, 0));
    vecs.push_back(mk(0, 2'b10, 0, 16'h0000, 16'h0400, 0, 5'h00, 1, 16'h0012, 16'h0400, 16'h4CC0, 5'h00, 1));
    vecs.push_back(mk(0, 2'b00, 0, 16'h0000, 16'h0000, 1, 5'h02, 1, 16'h0401, 16'h0400, 16'h4CC0, 5'h02, 0));
    vecs.push_back(mk(0, 2'b10, 0, 16'h0000, 16'h0800, 0, 5'h00, 1, 16'h0401, 16'h0401, 16'h4CC0, 5'h02, 0));
    vecs.push_back(mk(0, 2'b00, 1, 16'hC0FE, 16'h0000, 1, 5'h00, 1, 16'h0402, 16'h0401, 16'hC0FE, 5'h00, 0));
    vecs.push_back(mk(0, 2'b11, 0, 16'h0000, 16'h0000, 1, 5'h02, 1, 16'h0402, p15,      16'hC0FE, 5'h02, bt15));
    vecs.push_back(mk(0, 2'b00, 1, 16'h4E80, 16'h0000, 0, 5'h00, 1, p15 + 16'd1, p15,   16'h4E80, 5'h02, 0));
    vecs.push_back(mk(0, 2'b10, 0, 16'h0000, 16'hFFFF, 0, 5'h00, 1, p15 + 16'd1, 16'hFFFF, 16'h4E80, 5'h02, 1));
    vecs.push_back(mk(0, 2'b01, 0, 16'h0000, 16'h0000, 0, 5'h00, 1, 16'h0000, 16'h0000, 16'h4E80, 5'h02, 0));
    vecs.push_back(mk(0, 2'b00, 1, 16'hC0FE, 16'h0000, 0, 5'h00, 1, 16'h0001, 16'h0000, 16'hC0FE, 5'h02, 0));
    vecs.push_back(mk(0, 2'b11, 0, 16'h0000, 16'h0000, 0, 5'h00, 1, 16'h0001, 16'hFFFE, 16'hC0FE, 5'h02, 1));
    vecs.push_back(mk(1, 2'b11, 1, 16'h1234, 16'h0000, 1, 5'h1F, 1, 16'hFFFF, 16'h0000, 16'h0000, 5'h00, 0));
    vecs.push_back(mk(0, 2'b01, 0, 16'h0000, 16'h0000, 0, 5'h00, 1, 16'h0001, 16'h0001, 16'h0000, 5'h00, 0));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Condition sweep: load flags and a Bcond +3 together, then branch.
    pats[0] = 5'b00000; pats[1] = 5'b11111; pats[2] = 5'b01010; pats[3] = 5'b10101;
    epc = 16'h0001;
    for (int c = 0; c < 16; c++) begin
      for (int p = 0; p < 4; p++) begin
        logic [15:0] ir;
        ir = {4'h0, 4'(c), 8'h03};
        epc = epc + 16'd1;
        apply(mk(0, 2'b01, 1, ir, 16'h0000, 1, pats[p], 1, epc, epc, ir, pats[p], 0),
              1000 + c * 10 + p);
        tk = cond_ok(4'(c), pats[p]);
        apply(mk(0, 2'b11, 0, 16'h0000, 16'h0000, 0, 5'h00, 1, epc + 16'd1,
                 tk ? epc + 16'd3 : epc + 16'd1, ir, pats[p], tk),
              2000 + c * 10 + p);
        epc = tk ? epc + 16'd3 : epc + 16'd1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL provide port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL provide port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL provide port: pcEn  input  2  PC action; 00 hold, 01 increment, 10 jump (JAL/Jcond), 11 branch (Bcond).
REQ-004 SHALL provide port: pcRegEn  input  1  capture memData into instruction register.
REQ-005 SHALL provide port: memData  input  16  instruction word from memory.
REQ-006 SHALL provide port: jumpTarget  input  16  target register value for JAL/Jcond.
REQ-007 SHALL provide port: flagWrEn  input  1  latch ALU flags.
REQ-008 SHALL provide port: aluC, aluL, aluF, aluZ, aluN  input  1 each  flags from the ALU.
REQ-009 SHALL provide port: pc  output  16  current program counter, registered.
REQ-010 SHALL provide port: instruction  output  16  instruction register, registered.
REQ-011 SHALL provide port: C, L, F, Z, N  output  1 each  registered processor flags.
REQ-012 SHALL provide port: linkAddr  output  16  combinational pc+1, for JAL write-back.
REQ-013 SHALL provide port: branchTaken  output  1  registered one-cycle pulse after a taken jump/branch.

Function
REQ-014 pcRegEn=1 SHALL load instruction<=memData on the next edge; otherwise instruction SHALL hold.
REQ-015 flagWrEn=1 SHALL load {C,L,F,Z,N}<={aluC,aluL,aluF,aluZ,aluN}; otherwise flags SHALL hold.
REQ-016 pcEn=00 SHALL hold pc; pcEn=01 SHALL set pc<=pc+1.
REQ-017 All pc arithmetic SHALL be modulo 2^16 (16'hFFFF+1 -> 16'h0000; negative displacement below 0 wraps).
REQ-018 Condition code cond=instruction[11:8] SHALL evaluate as: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 HI L; 0101 LS !L; 0110 GT N; 0111 LE !N; 1000 FS F; 1001 FC !F; 1010 LO !L&!Z; 1011 HS L|Z; 1100 LT !N&!Z; 1101 GE N|Z; 1110 UC 1; 1111 never 0.
REQ-019 pcEn=10 with instruction[7:4]=1000 (JAL) SHALL set pc<=jumpTarget unconditionally.
REQ-020 pcEn=10 with any other instruction[7:4] (Jcond) SHALL set pc<=jumpTarget if cond true, else pc<=pc+1.
REQ-021 pcEn=11 (Bcond) SHALL set pc<=pc+sext(instruction[7:0]) if cond true, else pc<=pc+1.
REQ-022 branchTaken SHALL be 1 for exactly the cycle after an edge where pcEn[1]=1 and the jump/branch was taken; 0 otherwise.
REQ-023 Conditions SHALL use registered flags (see REQ-029 for bypass).
REQ-024 pcRegEn and nonzero pcEn in the same cycle SHALL both take effect; pc/cond use the pre-edge instruction value.
REQ-025 flagWrEn and a conditional pcEn in the same cycle SHALL update flags; condition follows REQ-023/REQ-029.
REQ-026 linkAddr SHALL equal pc+1 (wrapping) at all times, with zero latency.

Reset
REQ-027 reset=1 at a rising edge SHALL set pc=0, instruction=0, C=L=F=Z=N=0, branchTaken=0, overriding all other inputs.
REQ-028 Reset asserted mid-operation (any pcEn/pcRegEn/flagWrEn) SHALL discard the pending update; first post-reset cycle starts from pc=0.

Configuration
REQ-029 Macro FLAG_BYPASS_EN: when defined, a conditional jump/branch in a cycle with flagWrEn=1 SHALL evaluate cond on the alu* inputs; when undefined, cond SHALL always use registered flags.

Verification
REQ-030 Reset, then pcEn=01 for 3 cycles -> pc=3, branchTaken=0, instruction=0.
REQ-031 pc=16'hFFFF, pcEn=01 -> pc=16'h0000; linkAddr before edge=16'h0000.
REQ-032 pc=16'h0010, Z=1, instruction=16'hC0FE (BEQ -2), pcEn=11 -> pc=16'h000E, branchTaken=1 next cycle; same with Z=0 -> pc=16'h0011, branchTaken=0.
REQ-033 instruction=16'h4E8x (JAL), jumpTarget=16'h1234, pc=16'h0020, pcEn=10 -> linkAddr=16'h0021 before edge, pc=16'h1234 after.
REQ-034 Jcond LT (instruction=16'h4CCx), N=0, Z=0, jumpTarget=16'h0400 -> pc=16'h0400; with Z=1 -> pc=pc+1.
REQ-035 Registered Z=0, flagWrEn=1 with aluZ=1, BEQ pcEn=11 -> taken with FLAG_BYPASS_EN defined, not taken without; Z=1 after edge in both.
